// File: rtl/iir_voice_sequencer_if.sv
// Port bundle for the voice sequencer: sweep control strobes, the per-voice
// sample/DEL memory port, the shared IIR filter port and the mixer stream.
`timescale 1ns/1ps
interface iir_voice_sequencer_if #(
    parameter int VW = 3
);
    logic               sample_stb;
    logic               clr_stb;
    logic [VW-1:0]      clr_voice;
    logic [VW-1:0]      voice;
    logic signed [17:0] in_sample;
    logic signed [35:0] in_del;
    logic signed [17:0] iir_i;
    logic signed [35:0] iir_del;
    logic signed [17:0] iir_fb;
    logic signed [17:0] iir_o;
    logic               out_valid;
    logic [VW-1:0]      out_voice;
    logic signed [17:0] out_data;
    logic               busy;
    logic               done;
    logic               overrun;

    modport master (
        input  sample_stb, clr_stb, clr_voice, in_sample, in_del, iir_o,
        output voice, iir_i, iir_del, iir_fb, out_valid, out_voice, out_data,
               busy, done, overrun
    );

    modport slave (
        output sample_stb, clr_stb, clr_voice, in_sample, in_del, iir_o,
        input  voice, iir_i, iir_del, iir_fb, out_valid, out_voice, out_data,
               busy, done, overrun
    );
endinterface

// File: rtl/iir_voice_sequencer.sv
// Sweeps NVOICES voices through one shared one-pole IIR datapath per sample
// strobe, holding each voice's feedback sample and streaming results out.
`timescale 1ns/1ps
module iir_voice_sequencer #(
    parameter int NVOICES = 8,
    parameter int VW      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    iir_voice_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, ADDR, LOAD, CALC} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [VW-1:0]      v;
    logic signed [17:0] fb [NVOICES];
    logic               clr_pend;
    logic               last_voice;
    logic               clr_hit;

    assign last_voice = (v == VW'(NVOICES - 1));
    assign clr_hit    = bus.clr_stb && (bus.clr_voice == v);
    assign bus.voice  = v;
    assign bus.busy   = (state != IDLE);

    // NOTE: flops use non-blocking assignments so every register samples
    // pre-edge values regardless of the order processes are evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: next state is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.sample_stb) state_nxt = ADDR;
            ADDR:    state_nxt = LOAD;
            LOAD:    state_nxt = CALC;
            CALC:    state_nxt = last_voice ? IDLE : ADDR;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v             <= '0;
            bus.iir_i     <= '0;
            bus.iir_del   <= '0;
            bus.iir_fb    <= '0;
            bus.out_valid <= 1'b0;
            bus.out_voice <= '0;
            bus.out_data  <= '0;
            bus.done      <= 1'b0;
            bus.overrun   <= 1'b0;
            clr_pend      <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.done      <= 1'b0;
            bus.overrun   <= bus.sample_stb && (state != IDLE);
            // A clear of the in-flight voice during LOAD must still kill the CALC writeback.
            clr_pend      <= (state == LOAD) && clr_hit;
            case (state)
                IDLE: if (bus.sample_stb) v <= '0;
                LOAD: begin
                    bus.iir_i   <= bus.in_sample;
                    bus.iir_del <= bus.in_del;
                    bus.iir_fb  <= fb[v];
                end
                CALC: begin
                    bus.out_data  <= bus.iir_o;
                    bus.out_voice <= v;
                    bus.out_valid <= 1'b1;
                    bus.done      <= last_voice;
                    v             <= last_voice ? '0 : v + VW'(1);
                end
                default: ;
            endcase
        end
    end

    // NOTE: the feedback array is reset explicitly because reset must zero
    // every voice's filter history, not just the control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NVOICES; i++) fb[i] <= '0;
        end else begin
            if (state == CALC) fb[v] <= clr_pend ? '0 : bus.iir_o;
            // Placed last so a same-cycle clear overrides the writeback.
            if (bus.clr_stb) fb[bus.clr_voice] <= '0;
        end
    end
endmodule

// File: tb/tb_iir_voice_sequencer.sv
// Self-checking bench: sample/DEL memory and shared filter models around the
// sequencer, table vectors, directed corner cases and randomized sweeps.
`timescale 1ns/1ps
module tb_iir_voice_sequencer;
    localparam int NV   = 8;
    localparam int VW   = 3;
    localparam int NCYC = 3 * NV + 1;

    typedef struct {
        logic signed [17:0] in_s;
        logic signed [35:0] del;
        logic signed [17:0] exp_out;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    iir_voice_sequencer_if #(.VW(VW)) bus ();
    iir_voice_sequencer #(.NVOICES(NV), .VW(VW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    logic signed [17:0] mem_in   [NV];
    logic signed [35:0] mem_del  [NV];
    logic signed [17:0] fbm      [NV];
    logic signed [17:0] got_out  [NV];
    logic signed [17:0] got_fb   [NV];
    logic signed [17:0] prev_out [NV];
    int n_checks = 0;
    int n_pass   = 0;

    // Shared filter: b1 = DEL / 2^35, a0 = (2^35 - 1 - DEL) / 2^35, floored.
    function automatic logic signed [17:0] filt(input logic signed [17:0] i,
                                                input logic signed [35:0] d,
                                                input logic signed [17:0] f);
        longint a0, acc;
        a0  = 64'sd34359738367 - longint'(d);
        acc = longint'(i) * a0 + longint'(f) * longint'(d);
        return 18'(acc >>> 35);
    endfunction

    always @(posedge clk) begin
        bus.in_sample <= mem_in[bus.voice];
        bus.in_del    <= mem_del[bus.voice];
    end

    always_comb bus.iir_o = filt(bus.iir_i, bus.iir_del, bus.iir_fb);

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " voice"},     bus.voice,     0);
        check({tag, " iir_i"},     bus.iir_i,     0);
        check({tag, " iir_del"},   bus.iir_del,   0);
        check({tag, " iir_fb"},    bus.iir_fb,    0);
        check({tag, " out_valid"}, bus.out_valid, 0);
        check({tag, " out_voice"}, bus.out_voice, 0);
        check({tag, " out_data"},  bus.out_data,  0);
        check({tag, " busy"},      bus.busy,      0);
        check({tag, " done"},      bus.done,      0);
        check({tag, " overrun"},   bus.overrun,   0);
    endtask

    task automatic rand_mem();
        for (int k = 0; k < NV; k++) begin
            mem_in[k]  = 18'($urandom);
            mem_del[k] = {1'b0, 3'($urandom), $urandom};
        end
    endtask

    task automatic clear_all();
        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            bus.clr_stb   = 1'b1;
            bus.clr_voice = VW'(k);
            fbm[k]        = '0;
        end
        @(negedge clk);
        bus.clr_stb = 1'b0;
    endtask

    // One sweep: strobe in cycle 0, optional overrun strobe and one clear
    // (cycle clr_c, voice clr_v; clr_c < 0 means none).
    task automatic sweep(input int ovr_c, input int clr_c, input int clr_v);
        logic signed [17:0] e_out [NV];
        logic signed [17:0] e_fb  [NV];
        int k;
        for (int j = 0; j < NV; j++) begin
            // Clears landing before the LOAD read zero the feedback used;
            // clears at or after LOAD leave zero for the next sweep.
            e_fb[j] = (clr_c >= 0 && clr_v == j && clr_c < 3*j + 2) ? 18'sd0 : fbm[j];
            e_out[j] = filt(mem_in[j], mem_del[j], e_fb[j]);
            fbm[j] = (clr_c >= 0 && clr_v == j && clr_c >= 3*j + 2) ? 18'sd0 : e_out[j];
        end
        for (int c = 0; c <= NCYC + 1; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                check($sformatf("busy c%0d", c),      bus.busy,      c <= 3*NV);
                check($sformatf("done c%0d", c),      bus.done,      c == NCYC);
                check($sformatf("overrun c%0d", c),   bus.overrun,   ovr_c > 0 && c == ovr_c + 1);
                check($sformatf("out_valid c%0d", c), bus.out_valid, c >= 4 && (c - 4) % 3 == 0);
                if (c % 3 == 1 && c < 3*NV) begin
                    k = (c - 1) / 3;
                    check($sformatf("voice addr v%0d", k), bus.voice, k);
                end
                if (c % 3 == 0 && c <= 3*NV) begin
                    k = c / 3 - 1;
                    check($sformatf("iir_i v%0d", k),   bus.iir_i,   mem_in[k]);
                    check($sformatf("iir_del v%0d", k), bus.iir_del, mem_del[k]);
                    check($sformatf("iir_fb v%0d", k),  bus.iir_fb,  e_fb[k]);
                    got_fb[k] = bus.iir_fb;
                end
                if (c >= 4 && (c - 4) % 3 == 0) begin
                    k = (c - 4) / 3;
                    check($sformatf("out_voice v%0d", k), bus.out_voice, k);
                    check($sformatf("out_data v%0d", k),  bus.out_data,  e_out[k]);
                    got_out[k] = bus.out_data;
                end
            end
            bus.sample_stb = (c == 0) || (ovr_c > 0 && c == ovr_c);
            bus.clr_stb    = (c == clr_c);
            bus.clr_voice  = VW'(clr_v);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl [5];
        int   dn;
        tbl[0] = '{18'sh10000, 36'sh0,         18'sh0FFFF};
        tbl[1] = '{18'sh1FFFF, 36'sh0,         18'sh1FFFE};
        tbl[2] = '{18'sh20000, 36'sh0,         18'sh20000};
        tbl[3] = '{18'sh10000, 36'sh400000000, 18'sh07FFF};
        tbl[4] = '{18'sh30000, 36'sh400000000, 18'sh38000};

        bus.sample_stb = 1'b0;
        bus.clr_stb    = 1'b0;
        bus.clr_voice  = '0;
        rst_n          = 1'b0;
        for (int k = 0; k < NV; k++) begin
            mem_in[k] = '0; mem_del[k] = '0; fbm[k] = '0;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;

        // First sweep after reset: every feedback read must be zero.
        rand_mem();
        sweep(0, -1, 0);

        // Table vectors, all voices identical, feedback cleared beforehand.
        for (int t = 0; t < 5; t++) begin
            clear_all();
            for (int k = 0; k < NV; k++) begin
                mem_in[k] = tbl[t].in_s; mem_del[k] = tbl[t].del;
            end
            sweep(0, -1, 0);
            for (int k = 0; k < NV; k++)
                check($sformatf("table %0d out v%0d", t, k), got_out[k], tbl[t].exp_out);
        end

        // Feedback carry across two sweeps.
        rand_mem();
        mem_del[3] = 36'sh400000000;
        sweep(0, -1, 0);
        prev_out = got_out;
        sweep(0, -1, 0);
        for (int k = 0; k < NV; k++)
            check($sformatf("fb carry v%0d", k), got_fb[k], prev_out[k]);

        // Overruns mid-sweep and in the final CALC cycle.
        sweep(10, -1, 0);
        sweep(3*NV, -1, 0);

        // Clear collision in voice 5's CALC cycle.
        for (int k = 0; k < NV; k++) begin
            mem_in[k] = 18'sh08000 + 18'(k); mem_del[k] = '0;
        end
        sweep(0, 3*5 + 3, 5);
        sweep(0, -1, 0);
        check("clr collision fb v5", got_fb[5], 0);
        check("fb v4 nonzero", got_fb[4] != 0, 1);

        // Clears of the in-flight voice during ADDR and during LOAD.
        sweep(0, 3*2 + 1, 2);
        check("clr in addr fb v2", got_fb[2], 0);
        sweep(0, 3*6 + 2, 6);
        sweep(0, -1, 0);
        check("clr in load fb v6", got_fb[6], 0);

        // Randomized sweeps.
        for (int r = 0; r < 8; r++) begin
            rand_mem();
            sweep(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3*NV)) : 0,
                  ($urandom_range(0, 2) != 0) ? int'($urandom_range(0, NCYC)) : -1,
                  int'($urandom_range(0, NV - 1)));
        end

        // Asynchronous reset between edges.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("mid-clock");
        for (int k = 0; k < NV; k++) fbm[k] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        sweep(0, -1, 0);

        // Reset during voice 4 ADDR aborts the sweep without DONE.
        @(negedge clk);
        bus.sample_stb = 1'b1;
        @(negedge clk);
        bus.sample_stb = 1'b0;
        repeat (12) @(negedge clk);
        check("abort voice before reset", bus.voice, 4);
        rst_n = 1'b0;
        #1;
        check("abort busy", bus.busy, 0);
        check("abort done", bus.done, 0);
        check("abort out_valid", bus.out_valid, 0);
        for (int k = 0; k < NV; k++) fbm[k] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        check("no done after abort", dn, 0);
        rand_mem();
        sweep(0, -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
